// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: grant encoding, default widths and
// the posted-write FIFO entry layout.
package vram_arb_pkg;

    // Default VRAM geometry: 4 KiB of byte-wide words behind the CPU window.
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    // Owner of the VRAM port for one cycle.
    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_GPU    = 2'd1,
        GNT_CPU_WR = 2'd2,
        GNT_CPU_RD = 2'd3
    } grant_t;

    // One posted CPU write at the default geometry.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_entry_t;

    // A grant that turns into a RAM read (and later a returning rvalid).
    function automatic logic grant_is_read(input grant_t g);
        return (g == GNT_GPU) || (g == GNT_CPU_RD);
    endfunction

endpackage

// File: rtl/vram_wr_fifo_m.sv
// Small synchronous FIFO holding posted CPU writes until an idle VRAM slot.
// Push is refused when full and pop is refused when empty, so the caller
// may present both unconditionally. Pointers wrap naturally because DEPTH
// is a power of two.
module vram_wr_fifo_m
    import vram_arb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = DEF_ADDR_W + DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign level     = level_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and occupancy bookkeeping; push and pop together keep the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so stale writes can never resurface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between real-time GPU pixel fetches and
// CPU accesses. GPU reads always win; CPU writes are posted into a FIFO and
// drained in idle slots; CPU reads wait for the FIFO to empty so a read
// always observes every earlier write. All RAM-side signals are registered.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_sel,
    input  logic                        cpu_we,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic                        cpu_ready,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        cpu_rvalid,
    input  logic                        gpu_req,
    input  logic [ADDR_W-1:0]           gpu_addr,
    output logic [DATA_W-1:0]           gpu_rdata,
    output logic                        gpu_rvalid,
    output logic [ADDR_W-1:0]           vram_addr,
    output logic [DATA_W-1:0]           vram_wdata,
    output logic                        vram_we,
    output logic                        vram_re,
    input  logic [DATA_W-1:0]           vram_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        cpu_starved
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    grant_t             grant_s;
    grant_t             tag_r;
    entry_t             push_entry_s;
    entry_t             head_s;
    logic [ENTRY_W-1:0] head_bits_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic               cpu_rd_req_s;
    logic               cpu_rd_busy_s;
    logic               blocked_s;
    logic               starve_hit_s;
    logic [CNT_W-1:0]   starve_cnt_r;

    // A CPU read occupies the RAM cycle right after its grant; while that
    // read is on the RAM port a second read must not be granted.
    assign cpu_rd_req_s  = cpu_sel & ~cpu_we;
    assign cpu_rd_busy_s = vram_re & (tag_r == GNT_CPU_RD);

    // Fixed-priority grant: GPU, then FIFO drain, then a CPU read.
    always_comb begin
        grant_s = GNT_NONE;
        if (gpu_req) begin
            grant_s = GNT_GPU;
        end else if (!empty_s) begin
            grant_s = GNT_CPU_WR;
        end else if (cpu_rd_req_s && !cpu_rd_busy_s) begin
            grant_s = GNT_CPU_RD;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Full FIFO refuses the push outright, even when a pop frees a slot
    // in the same cycle.
    assign push_s       = cpu_sel & cpu_we & ~full_s;
    assign pop_s        = (grant_s == GNT_CPU_WR);
    assign cpu_ready    = push_s | (grant_s == GNT_CPU_RD);
    assign push_entry_s = {cpu_addr, cpu_wdata};
    assign head_s       = entry_t'(head_bits_s);

    vram_wr_fifo_m #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_bits_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (fifo_level)
    );

    // Register the winning access onto the RAM port and remember its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_addr  <= {ADDR_W{1'b0}};
            vram_wdata <= {DATA_W{1'b0}};
            vram_we    <= 1'b0;
            vram_re    <= 1'b0;
            tag_r      <= GNT_NONE;
        end else begin
            vram_we <= (grant_s == GNT_CPU_WR);
            vram_re <= grant_is_read(grant_s);
            tag_r   <= grant_s;
            case (grant_s)
                GNT_GPU: begin
                    vram_addr <= gpu_addr;
                end
                GNT_CPU_WR: begin
                    vram_addr  <= head_s.addr;
                    vram_wdata <= head_s.data;
                end
                GNT_CPU_RD: begin
                    vram_addr <= cpu_addr;
                end
                default: begin
                    vram_addr  <= vram_addr;
                    vram_wdata <= vram_wdata;
                end
            endcase
        end
    end

    // Steer the returning RAM data to whichever channel issued the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpu_rvalid <= 1'b0;
            gpu_rdata  <= {DATA_W{1'b0}};
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= {DATA_W{1'b0}};
        end else begin
            gpu_rvalid <= vram_re & (tag_r == GNT_GPU);
            cpu_rvalid <= vram_re & (tag_r == GNT_CPU_RD);
            if (vram_re && (tag_r == GNT_GPU)) begin
                gpu_rdata <= vram_rdata;
            end
            if (vram_re && (tag_r == GNT_CPU_RD)) begin
                cpu_rdata <= vram_rdata;
            end
        end
    end

    // CPU work is blocked when the GPU holds the port while writes are
    // queued or a read is waiting.
    assign blocked_s    = gpu_req & (~empty_s | cpu_rd_req_s);
    assign starve_hit_s = blocked_s & (starve_cnt_r >= CNT_W'(STARVE_LIMIT - 1));

    // Saturating count of consecutive blocked cycles; any unblocked cycle clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (blocked_s) begin
            if (starve_cnt_r != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Sticky starvation flag, set in step with the count reaching the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_starved <= 1'b0;
        end else if (starve_hit_s) begin
            cpu_starved <= 1'b1;
        end else begin
            cpu_starved <= cpu_starved;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a behavioural RAM plus a transaction-level model
// (write queue, memory image, read-return schedule) checked every cycle.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_sel;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        gpu_req;
    logic [11:0] gpu_addr;
    logic [7:0]  gpu_rdata;
    logic        gpu_rvalid;
    logic [11:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        vram_re;
    logic [7:0]  vram_rdata;
    logic [2:0]  fifo_level;
    logic        cpu_starved;

    vram_arbiter #(.ADDR_W(12), .DATA_W(8), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_rdata(gpu_rdata), .gpu_rvalid(gpu_rvalid),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
        .vram_rdata(vram_rdata), .fifo_level(fifo_level), .cpu_starved(cpu_starved)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: latches the registered address, data visible while vram_re is high.
    bit [7:0] ram [4096];
    assign vram_rdata = vram_re ? ram[vram_addr] : 8'h00;
    always @(posedge clk) begin
        if (vram_we) ram[vram_addr] <= vram_wdata;
    end

    // Reference model state
    wr_entry_t   wq[$];
    bit [7:0]    mem_m [4096];
    int          cyc;
    int          rd_due;
    int          starve_cnt;
    bit          starved_m;
    bit          e_we, e_re;
    bit [11:0]   e_addr;
    bit [7:0]    e_wdata;
    int          s1_kind;        // 0 none, 1 gpu, 2 cpu: read on the RAM port this cycle
    bit [11:0]   s1_addr;
    bit          e_gv, e_cv;
    bit [7:0]    e_gd, e_cd;
    bit          last_acc;

    int n_cmp;
    int n_err;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        rd_due = 0; starve_cnt = 0; starved_m = 1'b0;
        e_we = 1'b0; e_re = 1'b0; e_addr = 12'h000; e_wdata = 8'h00;
        s1_kind = 0; s1_addr = 12'h000;
        e_gv = 1'b0; e_cv = 1'b0; e_gd = 8'h00; e_cd = 8'h00;
        last_acc = 1'b0;
    endtask

    // Called at a negedge: asynchronous reset, outputs must clear immediately.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        cpu_sel = 1'b0; cpu_we = 1'b0; gpu_req = 1'b0;
        #1;
        model_reset();
        check_value("rst_vram_we", vram_we, 0);
        check_value("rst_vram_re", vram_re, 0);
        check_value("rst_vram_addr", vram_addr, 0);
        check_value("rst_vram_wdata", vram_wdata, 0);
        check_value("rst_gpu_rvalid", gpu_rvalid, 0);
        check_value("rst_cpu_rvalid", cpu_rvalid, 0);
        check_value("rst_fifo_level", fifo_level, 0);
        check_value("rst_cpu_starved", cpu_starved, 0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: decide from the rules, check ready, then check registered outputs.
    task automatic tick();
        int        g;
        int        n_kind;
        bit        push, acc, blocked, n_we, n_re;
        bit [11:0] n_addr;
        bit [7:0]  n_wdata;
        wr_entry_t ent;
        #1;
        if (gpu_req) g = 1;
        else if (wq.size() != 0) g = 2;
        else if (cpu_sel && !cpu_we && cyc >= rd_due) g = 3;
        else g = 0;
        push    = cpu_sel && cpu_we && (wq.size() < DEPTH);
        acc     = push || (g == 3);
        blocked = gpu_req && ((wq.size() != 0) || (cpu_sel && !cpu_we));
        check_value("cpu_ready", cpu_ready, acc);
        last_acc = acc;
        n_we = (g == 2); n_re = (g == 1) || (g == 3);
        n_addr = e_addr; n_wdata = e_wdata; n_kind = 0;
        if (g == 1) begin
            n_addr = gpu_addr; n_kind = 1;
        end else if (g == 3) begin
            n_addr = cpu_addr; n_kind = 2; rd_due = cyc + 2;
        end else if (g == 2) begin
            ent = wq.pop_front();
            n_addr = ent.addr; n_wdata = ent.data;
        end
        if (push) begin
            ent.addr = cpu_addr; ent.data = cpu_wdata;
            wq.push_back(ent);
        end
        @(posedge clk);
        #1;
        e_gv = (s1_kind == 1); e_cv = (s1_kind == 2);
        if (e_gv) e_gd = mem_m[s1_addr];
        if (e_cv) e_cd = mem_m[s1_addr];
        if (e_we) mem_m[e_addr] = e_wdata;
        e_we = n_we; e_re = n_re; e_addr = n_addr; e_wdata = n_wdata;
        s1_kind = n_kind; s1_addr = n_addr;
        if (blocked) starve_cnt = (starve_cnt < LIMIT) ? starve_cnt + 1 : LIMIT;
        else starve_cnt = 0;
        if (starve_cnt >= LIMIT) starved_m = 1'b1;
        cyc++;
        check_value("vram_we", vram_we, e_we);
        check_value("vram_re", vram_re, e_re);
        check_value("we_re_exclusive", vram_we & vram_re, 0);
        if (e_we || e_re) check_value("vram_addr", vram_addr, e_addr);
        if (e_we) check_value("vram_wdata", vram_wdata, e_wdata);
        check_value("gpu_rvalid", gpu_rvalid, e_gv);
        if (e_gv) check_value("gpu_rdata", gpu_rdata, e_gd);
        check_value("cpu_rvalid", cpu_rvalid, e_cv);
        if (e_cv) check_value("cpu_rdata", cpu_rdata, e_cd);
        check_value("fifo_level", fifo_level, wq.size());
        check_value("cpu_starved", cpu_starved, starved_m);
        @(negedge clk);
    endtask

    task automatic cpu_start(input bit we, input logic [11:0] a, input logic [7:0] d);
        cpu_sel = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    // Tick and drop the CPU request once the model says it was accepted.
    task automatic tick_cpu();
        tick();
        if (last_acc) cpu_sel = 1'b0;
    endtask

    task automatic idle(input int n);
        gpu_req = 1'b0;
        for (int i = 0; i < n; i++) tick_cpu();
    endtask

    initial begin
        int k;
        int pct;
        n_cmp = 0; n_err = 0; cyc = 0;
        cpu_addr = 12'h000; cpu_wdata = 8'h00; gpu_addr = 12'h000;
        do_reset(2);

        // Single posted write with GPU idle
        cpu_start(1'b1, 12'h123, 8'hA5);
        tick_cpu();
        idle(4);

        // GPU holds the port for 10 cycles while the CPU tries 5 writes
        k = 0;
        for (int i = 0; i < 10; i++) begin
            gpu_req = 1'b1; gpu_addr = 12'h123 + 12'(i);
            if (!cpu_sel && k < 5) begin
                cpu_start(1'b1, 12'h200 + 12'(k), 8'h50 + 8'(k)); k++;
            end
            tick_cpu();
        end
        gpu_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!cpu_sel && k < 5) begin
                cpu_start(1'b1, 12'h200 + 12'(k), 8'h50 + 8'(k)); k++;
            end
            tick_cpu();
        end
        check_value("burst_all_posted", k, 5);
        idle(3);

        // Write then immediate read of the same address
        cpu_start(1'b1, 12'h010, 8'h3C);
        tick_cpu();
        cpu_start(1'b0, 12'h010, 8'h00);
        for (int i = 0; i < 30 && cpu_sel; i++) tick_cpu();
        check_value("rd_after_wr_accepted", cpu_sel, 0);
        idle(4);

        // GPU request and CPU read in the same cycle, FIFO empty
        gpu_req = 1'b1; gpu_addr = 12'h200;
        cpu_start(1'b0, 12'h010, 8'h00);
        tick_cpu();
        gpu_req = 1'b0;
        for (int i = 0; i < 10 && cpu_sel; i++) tick_cpu();
        check_value("rd_after_gpu_accepted", cpu_sel, 0);
        idle(4);

        // Starvation: one pending write behind a 70-cycle GPU burst
        @(negedge clk);
        do_reset(1);
        cpu_start(1'b1, 12'h0AA, 8'h77);
        for (int i = 0; i < 70; i++) begin
            gpu_req = 1'b1; gpu_addr = 12'(i);
            tick_cpu();
        end
        idle(6);

        // Reset with three writes queued behind the GPU
        k = 0;
        for (int i = 0; i < 8 && k < 3; i++) begin
            gpu_req = 1'b1; gpu_addr = 12'h300;
            if (!cpu_sel) begin
                cpu_start(1'b1, 12'h0B0 + 12'(k), 8'hC0 + 8'(k));
            end
            tick_cpu();
            if (last_acc) k++;
        end
        check_value("three_queued", fifo_level, 3);
        do_reset(1);
        idle(5);

        // Reset with a CPU read on the RAM port
        cpu_start(1'b0, 12'h200, 8'h00);
        tick_cpu();
        do_reset(1);
        idle(5);

        // Randomized traffic with varying GPU load
        for (int blk = 0; blk < 9; blk++) begin
            pct = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 30 : 5);
            for (int i = 0; i < 100; i++) begin
                gpu_req  = ($urandom_range(0, 99) < pct);
                gpu_addr = 12'($urandom_range(0, 15));
                if (!cpu_sel && $urandom_range(0, 99) < 40) begin
                    cpu_start(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                end
                tick_cpu();
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
